// File: rtl/decoder_pkg.sv
// Shared opcode constants, field positions, FSM encoding and the
// instruction-class decode used by the pipelined decoder.
package decoder_pkg;

  // Major opcodes, instr[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_HLT = 3'b111;

  // Sub-op codes, instr[12:11]
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MEM_OP  = 2'b00;

  // Field bit positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int OP_MSB   = 12;
  localparam int OP_LSB   = 11;
  localparam int RN_MSB   = 10;
  localparam int RN_LSB   = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 5;
  localparam int SH_MSB   = 4;
  localparam int SH_LSB   = 3;
  localparam int RM_MSB   = 2;
  localparam int RM_LSB   = 0;
  localparam int IMM5_MSB = 4;
  localparam int IMM8_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD0   = 2'd1,
    ST_RD1   = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] nreads;
    logic [2:0] src0;
    logic [2:0] src1;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic       illegal;
  } dec_info_t;

  // Register read plan and write-back target for one instruction word.
  // Non-writing classes report wr_sel=0 so the bundle never shows a stale index.
  function automatic dec_info_t decode_class(input logic [15:0] instr);
    dec_info_t  info;
    logic [2:0] opc;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    opc  = instr[OPC_MSB:OPC_LSB];
    op   = instr[OP_MSB:OP_LSB];
    rn   = instr[RN_MSB:RN_LSB];
    rd   = instr[RD_MSB:RD_LSB];
    rm   = instr[RM_MSB:RM_LSB];
    info = '0;
    case (opc)
      OPC_MOV: begin
        if (op == MOV_IMM) begin
          info.wr_en  = 1'b1;
          info.wr_sel = rn;
        end else if (op == MOV_REG) begin
          info.nreads = 2'd1;
          info.src0   = rm;
          info.wr_en  = 1'b1;
          info.wr_sel = rd;
        end else begin
          info.illegal = 1'b1;
        end
      end
      OPC_ALU: begin
        case (op)
          ALU_ADD, ALU_AND: begin
            info.nreads = 2'd2;
            info.src0   = rn;
            info.src1   = rm;
            info.wr_en  = 1'b1;
            info.wr_sel = rd;
          end
          ALU_CMP: begin
            info.nreads = 2'd2;
            info.src0   = rn;
            info.src1   = rm;
          end
          default: begin
            info.nreads = 2'd1;
            info.src0   = rm;
            info.wr_en  = 1'b1;
            info.wr_sel = rd;
          end
        endcase
      end
      OPC_LDR: begin
        if (op == MEM_OP) begin
          info.nreads = 2'd1;
          info.src0   = rn;
          info.wr_en  = 1'b1;
          info.wr_sel = rd;
        end else begin
          info.illegal = 1'b1;
        end
      end
      OPC_STR: begin
        if (op == MEM_OP) begin
          info.nreads = 2'd2;
          info.src0   = rn;
          info.src1   = rd;
        end else begin
          info.illegal = 1'b1;
        end
      end
      OPC_HLT: begin
        info = '0;
      end
      default: begin
        info.illegal = 1'b1;
      end
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer. Count distinguishes full from empty because
// both pointers wrap modulo DEPTH; flush discards everything at the next edge.
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy update; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Buffered instruction decoder: pops instructions from a FIFO, sequences
// up to two register-file reads, then holds the decoded bundle until the
// datapath controller accepts it.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | nothing in IR; pop the FIFO head as soon as one exists
//   ST_RD0   | rd_en with the first source operand of IR
//   ST_RD1   | rd_en with the second source operand of IR
//   ST_ISSUE | out_valid, bundle held; on accept pop next or go idle
module pipelined_instruction_decoder
  import decoder_pkg::*;
#(
  parameter int DW     = 16,
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [15:0]   in_instr,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          rd_en,
  output logic [2:0]    rd_num,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [1:0]    alu_op,
  output logic [1:0]    shift,
  output logic [DW-1:0] sximm5,
  output logic [DW-1:0] sximm8,
  output logic          wr_en,
  output logic [2:0]    wr_num,
  output logic          illegal,
  output logic          halt,
  output logic          busy
);

  localparam int AW = $clog2(QDEPTH);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        pop;
  dec_info_t   ir_info;
  dec_info_t   head_info;

  assign ir_info   = decode_class(ir_q);
  assign head_info = decode_class(fifo_rdata);

  instr_fifo #(
    .WIDTH (16),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (in_valid),
    .wdata_i (in_instr),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next state, IR load and FIFO pop; a freshly loaded instruction skips
  // straight to ISSUE when it needs no register reads
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      ir_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            ir_d    = fifo_rdata;
            state_d = (head_info.nreads != 2'd0) ? ST_RD0 : ST_ISSUE;
          end
        end
        ST_RD0: begin
          state_d = (ir_info.nreads == 2'd2) ? ST_RD1 : ST_ISSUE;
        end
        ST_RD1: begin
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              ir_d    = fifo_rdata;
              state_d = (head_info.nreads != 2'd0) ? ST_RD0 : ST_ISSUE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Register-read strobe and index, only in the read states
  always_comb begin
    rd_en  = 1'b0;
    rd_num = '0;
    case (state_q)
      ST_RD0: begin
        rd_en  = 1'b1;
        rd_num = ir_info.src0;
      end
      ST_RD1: begin
        rd_en  = 1'b1;
        rd_num = ir_info.src1;
      end
      default: begin
        rd_en  = 1'b0;
        rd_num = '0;
      end
    endcase
  end

  assign in_ready  = !fifo_full;
  assign out_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  // Field outputs come straight from IR; the class flags are qualified by
  // out_valid so a cleared IR (opcode 000) does not read as illegal
  assign opcode  = ir_q[OPC_MSB:OPC_LSB];
  assign op      = ir_q[OP_MSB:OP_LSB];
  assign alu_op  = ir_q[OP_MSB:OP_LSB];
  assign shift   = ir_q[SH_MSB:SH_LSB];
  assign sximm5  = {{(DW-IMM5_MSB-1){ir_q[IMM5_MSB]}}, ir_q[IMM5_MSB:0]};
  assign sximm8  = {{(DW-IMM8_MSB-1){ir_q[IMM8_MSB]}}, ir_q[IMM8_MSB:0]};
  assign wr_num  = ir_info.wr_sel;
  assign wr_en   = out_valid && ir_info.wr_en;
  assign illegal = out_valid && ir_info.illegal;
  assign halt    = out_valid && (ir_q[OPC_MSB:OPC_LSB] == OPC_HLT);

endmodule
